// File: rtl/puf_report_pkg.sv
// rtl/puf_report_pkg.sv - shared constants and FSM state type for the PUF UART reporter (frame length follows PUF_REPORT_CHECKSUM_EN)
package puf_report_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Captured payload: challenge, response, 16 digest bytes.
    localparam int BUF_BYTES = 18;

`ifdef PUF_REPORT_CHECKSUM_EN
    localparam int FRAME_BYTES = 20;
`else
    localparam int FRAME_BYTES = 19;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 serializer for one byte with baud counting and start/done handshake
module uart_tx_byte #(
    parameter int DIV = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       bit_end,
    output logic       done
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic          active;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    // Bits still to be shifted out after the current one: data LSB first, then stop.
    logic [8:0]    shreg;
    logic          baud_end;

    assign baud_end = (baud_cnt == CW'(DIV - 1));
    assign bit_end  = active && baud_end;
    // done marks the last cycle of the stop bit so the next byte can start with no gap.
    assign done     = bit_end && (bit_cnt == 4'd9);

    // Bit sequencing: start loads a fresh byte even in the final stop-bit cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx       <= 1'b1;
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '1;
        end else if (start && (!active || done)) begin
            tx       <= 1'b0;
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= {1'b1, data};
        end else if (active) begin
            if (baud_end) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/puf_uart_reporter.sv
// rtl/puf_uart_reporter.sv - streams challenge/response/digest frames over UART 8N1 (checksum byte with PUF_REPORT_CHECKSUM_EN)
module puf_uart_reporter
    import puf_report_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   challenge,
    input  logic [7:0]   response,
    input  logic [127:0] digest,
    input  logic         valid,
    output logic         tx,
    output logic         busy,
    output logic [7:0]   dropped
);

    localparam int DIV = CLK_HZ / BAUD;

    state_t      state;
    logic        valid_q;
    logic        trigger;
    logic [7:0]  frame_buf [BUF_BYTES];
    logic [4:0]  byte_idx;
    logic [2:0]  data_cnt;
    logic        launch;
    logic [7:0]  cur_byte;
    logic        more_bytes;
    logic        frame_end;
    logic        accept;
    logic        u_start;
    logic        u_bit_end;
    logic        u_done;

`ifdef PUF_REPORT_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign trigger    = valid && !valid_q;
    // byte_idx is the index of the next byte to hand to the serializer.
    assign more_bytes = (byte_idx != 5'(FRAME_BYTES));
    assign frame_end  = (state == ST_STOP) && u_done && !more_bytes;
    // A trigger landing on the frame's final edge counts as arriving in IDLE.
    assign accept     = trigger && ((state == ST_IDLE) || frame_end);
    assign u_start    = launch || (u_done && more_bytes);

    // Rising-edge detector history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) valid_q <= 1'b0;
        else          valid_q <= valid;
    end

    // Payload capture on an accepted trigger; later input changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF_BYTES; i++) frame_buf[i] <= '0;
        end else if (accept) begin
            frame_buf[0] <= challenge;
            frame_buf[1] <= response;
            for (int i = 0; i < 16; i++) frame_buf[2 + i] <= digest[8*(15 - i) +: 8];
        end
    end

    // Byte selection: sync, payload, then optional checksum.
    always_comb begin
        cur_byte = SYNC_BYTE;
        if (byte_idx != 5'd0 && byte_idx <= 5'(BUF_BYTES)) cur_byte = frame_buf[byte_idx - 5'd1];
`ifdef PUF_REPORT_CHECKSUM_EN
        else if (byte_idx == 5'(BUF_BYTES + 1)) cur_byte = csum;
`endif
    end

    // Frame launch pulse one cycle after acceptance, and byte index sequencing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            launch   <= 1'b0;
            byte_idx <= '0;
        end else begin
            launch <= accept;
            if (accept)       byte_idx <= '0;
            else if (u_start) byte_idx <= byte_idx + 5'd1;
        end
    end

`ifdef PUF_REPORT_CHECKSUM_EN
    // Running XOR of every byte handed to the serializer, restarted with the sync byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     csum <= 8'h00;
        else if (u_start) csum <= (launch ? 8'h00 : csum) ^ cur_byte;
    end
`endif

    // Frame FSM tracking the bit phase of the byte on the line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            data_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) state <= ST_START;
                end
                ST_START: begin
                    if (u_bit_end) begin
                        state    <= ST_DATA;
                        data_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (u_bit_end) begin
                        if (data_cnt == 3'd7) state <= ST_STOP;
                        else                  data_cnt <= data_cnt + 3'd1;
                    end
                end
                ST_STOP: begin
                    if (u_done) state <= (more_bytes || accept) ? ST_START : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // busy spans from the first start bit to the end of the final stop bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       busy <= 1'b0;
        else if (launch)    busy <= 1'b1;
        else if (frame_end) busy <= 1'b0;
    end

    // Saturating count of triggers that could not start a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                  dropped <= 8'h00;
        else if (trigger && !accept && dropped != 8'hFF) dropped <= dropped + 8'd1;
    end

    uart_tx_byte #(.DIV(DIV)) u_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (u_start),
        .data    (cur_byte),
        .tx      (tx),
        .bit_end (u_bit_end),
        .done    (u_done)
    );

endmodule

// File: tb/tb_puf_uart_reporter.sv
// tb/tb_puf_uart_reporter.sv - self-checking bench for puf_uart_reporter
module tb_puf_uart_reporter;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DIV    = 10;
`ifdef PUF_REPORT_CHECKSUM_EN
    localparam int NB = 20;
`else
    localparam int NB = 19;
`endif
    localparam int FRAME_CYC = 10 * DIV * NB;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [7:0]   challenge = 8'h00;
    logic [7:0]   response = 8'h00;
    logic [127:0] digest = '0;
    logic         valid = 1'b0;
    logic         tx;
    logic         busy;
    logic [7:0]   dropped;

    int n_tests = 0;
    int n_fail  = 0;

    puf_uart_reporter #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .challenge (challenge),
        .response  (response),
        .digest    (digest),
        .valid     (valid),
        .tx        (tx),
        .busy      (busy),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    // Host-side UART receiver: mid-bit sampling from each falling edge on an idle line.
    logic [7:0] rx_q [$];
    logic [7:0] exp_f [$];
    int         framing_err = 0;
    int         busy_cnt = 0;
    bit         rx_on = 1'b0;
    int         rx_t = 0;
    logic [9:0] rx_bits;
    logic       tx_prev = 1'b1;

    always @(negedge clk) begin
        if (!reset_n) begin
            rx_on   = 1'b0;
            tx_prev = 1'b1;
        end else begin
            if (busy === 1'b1) busy_cnt++;
            if (!rx_on && tx_prev === 1'b1 && tx === 1'b0) begin
                rx_on = 1'b1;
                rx_t  = 0;
            end
            if (rx_on) begin
                if (rx_t % DIV == DIV / 2) rx_bits[rx_t / DIV] = tx;
                if (rx_t == 9 * DIV + DIV / 2) begin
                    if (rx_bits[0] !== 1'b0 || rx_bits[9] !== 1'b1) framing_err++;
                    rx_q.push_back(rx_bits[8:1]);
                    rx_on = 1'b0;
                end
                rx_t++;
            end
            tx_prev = tx;
        end
    end

    typedef struct {
        logic [7:0]   c;
        logic [7:0]   r;
        logic [127:0] d;
        logic [7:0]   x;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] frame_xor(input logic [7:0] c, input logic [7:0] r, input logic [127:0] d);
        logic [7:0] x;
        x = 8'hA5 ^ c ^ r;
        for (int j = 0; j < 16; j++) x ^= d[8*j +: 8];
        return x;
    endfunction

    // Reference frame: sync, challenge, response, digest MSB byte first, optional XOR byte.
    task automatic build_model(input logic [7:0] c, input logic [7:0] r, input logic [127:0] d);
        exp_f.push_back(8'hA5);
        exp_f.push_back(c);
        exp_f.push_back(r);
        for (int i = 15; i >= 0; i--) exp_f.push_back(d[8*i +: 8]);
`ifdef PUF_REPORT_CHECKSUM_EN
        exp_f.push_back(frame_xor(c, r, d));
`endif
    endtask

    task automatic clear_obs();
        rx_q.delete();
        exp_f.delete();
        framing_err = 0;
        busy_cnt    = 0;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] r, input logic [127:0] d);
        @(negedge clk);
        challenge = c;
        response  = r;
        digest    = d;
        valid     = 1'b1;
        @(negedge clk);
        valid     = 1'b0;
        challenge = 8'($urandom);
        response  = 8'($urandom);
        digest    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 3 * FRAME_CYC) begin
            @(negedge clk);
            t++;
        end
        check({name, " timeout"}, 32'(t < 3 * FRAME_CYC), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_rx(input string name, input int exp_busy);
        check({name, " nbytes"}, rx_q.size(), exp_f.size());
        for (int i = 0; i < exp_f.size() && i < rx_q.size(); i++)
            check($sformatf("%s byte%0d", name, i), rx_q[i], exp_f[i]);
        check({name, " framing"}, framing_err, 0);
        check({name, " busy cycles"}, busy_cnt, exp_busy);
    endtask

    task automatic run_frame(input string name, input logic [7:0] c, input logic [7:0] r, input logic [127:0] d);
        clear_obs();
        build_model(c, r, d);
        send(c, r, d);
        wait_idle(name);
        check_rx(name, FRAME_CYC);
    endtask

    initial begin
        int low;
        logic [7:0] x;

        tbl[0].c = 8'h3C; tbl[0].r = 8'h5A;
        tbl[0].d = 128'h00112233_44556677_8899AABB_CCDDEEFF; tbl[0].x = 8'hC3;
        tbl[1].c = 8'h01; tbl[1].r = 8'h02; tbl[1].d = '0; tbl[1].x = 8'hA6;
        for (int i = 2; i < 4; i++) begin
            tbl[i].c = 8'($urandom);
            tbl[i].r = 8'($urandom);
            tbl[i].d = {$urandom, $urandom, $urandom, $urandom};
            tbl[i].x = frame_xor(tbl[i].c, tbl[i].r, tbl[i].d);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset dropped", dropped, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven frames with start-bit timing
        for (int v = 0; v < 4; v++) begin
            clear_obs();
            build_model(tbl[v].c, tbl[v].r, tbl[v].d);
            send(tbl[v].c, tbl[v].r, tbl[v].d);
            check($sformatf("v%0d tx before N+1", v), tx, 1);
            check($sformatf("v%0d busy before N+1", v), busy, 0);
            low = 0;
            @(negedge clk);
            check($sformatf("v%0d busy at N+1", v), busy, 1);
            while (tx === 1'b0 && low < 30) begin
                low++;
                @(negedge clk);
            end
            check($sformatf("v%0d start bit cycles", v), low, DIV);
            check($sformatf("v%0d sync lsb", v), tx, 1);
            wait_idle($sformatf("v%0d", v));
            check_rx($sformatf("v%0d", v), FRAME_CYC);
            x = 8'h00;
            for (int i = 0; i < 19 && i < rx_q.size(); i++) x ^= rx_q[i];
            check($sformatf("v%0d payload xor", v), x, tbl[v].x);
`ifdef PUF_REPORT_CHECKSUM_EN
            check($sformatf("v%0d checksum byte", v), (rx_q.size() > 19) ? rx_q[19] : 8'hxx, tbl[v].x);
`endif
            check($sformatf("v%0d dropped", v), dropped, 0);
        end

        // Overrun: triggers mid-frame are dropped and saturate
        clear_obs();
        build_model(tbl[0].c, tbl[0].r, tbl[0].d);
        send(tbl[0].c, tbl[0].r, tbl[0].d);
        repeat (500) @(negedge clk);
        send(8'hFF, 8'hEE, '1);
        @(negedge clk);
        check("overrun dropped 1", dropped, 1);
        for (int i = 0; i < 300; i++) send(8'($urandom), 8'($urandom), {$urandom, $urandom, $urandom, $urandom});
        @(negedge clk);
        check("overrun dropped sat", dropped, 255);
        wait_idle("overrun");
        check_rx("overrun", FRAME_CYC);

        // Reset clears the drop counter
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("reset2 dropped", dropped, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Trigger on the same edge busy falls starts the next frame one cycle later
        clear_obs();
        build_model(tbl[1].c, tbl[1].r, tbl[1].d);
        build_model(tbl[2].c, tbl[2].r, tbl[2].d);
        send(tbl[1].c, tbl[1].r, tbl[1].d);
        repeat (FRAME_CYC) @(negedge clk);
        check("b2b busy before end", busy, 1);
        challenge = tbl[2].c;
        response  = tbl[2].r;
        digest    = tbl[2].d;
        valid     = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("b2b busy gap", busy, 0);
        check("b2b tx gap", tx, 1);
        @(negedge clk);
        check("b2b busy restart", busy, 1);
        check("b2b tx start", tx, 0);
        wait_idle("b2b");
        check_rx("b2b", 2 * FRAME_CYC);
        check("b2b dropped", dropped, 0);

        // Held valid: only one frame
        clear_obs();
        build_model(tbl[3].c, tbl[3].r, tbl[3].d);
        @(negedge clk);
        challenge = tbl[3].c;
        response  = tbl[3].r;
        digest    = tbl[3].d;
        valid     = 1'b1;
        repeat (FRAME_CYC + 500) @(negedge clk);
        valid = 1'b0;
        wait_idle("held");
        check_rx("held", FRAME_CYC);
        check("held dropped", dropped, 0);

        // Reset mid-frame, then a clean frame
        clear_obs();
        send(tbl[2].c, tbl[2].r, tbl[2].d);
        repeat (700) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset tx", tx, 1);
        check("midreset busy", busy, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("midreset idle tx", tx, 1);
        check("midreset idle busy", busy, 0);
        run_frame("after reset", tbl[0].c, tbl[0].r, tbl[0].d);

        // Randomized frames
        for (int k = 0; k < 3; k++)
            run_frame($sformatf("rand%0d", k), 8'($urandom), 8'($urandom), {$urandom, $urandom, $urandom, $urandom});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/puf_uart_reporter.md
# puf_uart_reporter

Downstream stage of the encrypted-PUF top level. On each new valid result it captures the challenge, the raw PUF response and the 128-bit hash digest, then streams them to a host PC as a framed byte packet over a UART 8N1 transmit line. The host can log challenge/response/digest triples without reading the seven-segment display.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, UART bit rate; DIV = CLK_HZ / BAUD (integer, truncated), must be ≥ 2

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- challenge  input  8  challenge associated with the current result
- response  input  8  raw PUF response
- digest  input  128  hash output, byte 15 = digest[127:120]
- valid  input  1  result valid level from the PUF/hash stage
- tx  output  1  UART serial out, idle high
- busy  output  1  high while a frame is being sent
- dropped  output  8  saturating count of results ignored while busy

One clock; reset is asynchronous and active-low.

## Operation
- Trigger: rising edge of valid (valid high now, low in the previous cycle). valid held high does not retrigger.
- On trigger in IDLE: latch challenge, response and digest into an 18-byte frame buffer; enter START.
- Frame byte order: 0xA5 sync, challenge, response, digest bytes 15 down to 0 (MSB byte first). 19 bytes total (20 with checksum, see Configuration).
- Each byte: start bit (0), 8 data bits LSB-first, stop bit (1); each bit held exactly DIV cycles.
- FSM states: IDLE, START, DATA, STOP. IDLE→START on trigger; START→DATA after DIV cycles; DATA→STOP after 8 bits; STOP→START if bytes remain, else STOP→IDLE.
- No inter-byte gap beyond the stop bit.
- Trigger while busy: frame not restarted or queued; dropped increments, saturating at 255.
- Inputs changing after the trigger cycle do not affect the frame in flight.
- Reset values: tx = 1, busy = 0, dropped = 0, state IDLE, buffer cleared, previous-valid register = 0.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously), frame abandoned; no partial resume after release.

## Timing
- Trigger sampled on edge N; busy = 1 and tx = 0 (start bit of sync byte) from edge N+1.
- Bit k of the frame (0-based, 10 bits per byte) occupies cycles N+1+k·DIV through N+(k+1)·DIV.
- busy falls on edge N+1+10·DIV·B, with B = 19 (or 20). A trigger on that same edge is accepted (IDLE entered and trigger seen together) and starts the next frame one cycle later without incrementing dropped.
- The final stop bit is always held its full DIV cycles before busy falls.
- Baud counter restarts at every bit boundary; no cumulative drift beyond truncation of DIV.

## Configuration
- PUF_REPORT_CHECKSUM_EN defined: a 20th byte follows digest byte 0. It is the XOR of all 19 preceding bytes, including 0xA5.
- Not defined: frame is 19 bytes; no checksum logic is synthesized.

## Structure
- Package puf_report_pkg holds:
  - SYNC_BYTE = 8'hA5
  - FRAME_BYTES (19/20, selected by the macro)
  - state enum type
- Sub-module uart_tx_byte, with a start/byte/done handshake, does the bit-level serialization and baud counting. The top FSM sequences bytes and computes the checksum.

## Test plan
All scenarios use CLK_HZ = 1000, BAUD = 100 (DIV = 10).
- Basic frame: pulse valid with challenge = 0x3C, response = 0x5A, digest = 0x00112233_44556677_8899AABB_CCDDEEFF → decoded bytes A5 3C 5A 00 11 … FF; busy high for 1900 cycles (2000 with checksum).
- Bit timing: check tx low exactly 10 cycles for the start bit and first data bit = 1 (LSB of 0xA5), one cycle after the trigger edge.
- Overrun: second valid rising edge 500 cycles into a frame → frame unchanged, dropped = 1; 300 extra edges → dropped saturates at 255.
- Held valid: valid held high across a full frame → exactly one frame sent, dropped = 0.
- Reset mid-frame: assert reset_n low at cycle 700 → tx = 1 and busy = 0 immediately; after release a new trigger sends a complete, correct frame.
- Checksum (macro defined): digest all zeros, challenge = 0x01, response = 0x02 → 20th byte = A5^01^02 = 0xA6.
